addsub_sequencer: RTL

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

---
 rtl/addsub_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/addsub_sequencer.sv
// Issues LOAD/ADD/SUB/ADDAB commands to an external 2-stage adder/subtractor and buffers its results in order.
// Latency: command accepted at edge t -> result captured at edge t+3, visible at res_valid after that edge.
// Backpressure: credit based, cmd_ready only while buffered + in-flight results leave room in the buffer.

module addsub_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic                     head_vld_o,
    output logic [W-1:0]             head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
endmodule

module addsub_sequencer #(
    parameter int n     = 16,
    parameter int DEPTH = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    output logic [n-1:0] A,
    output logic [n-1:0] B,
    output logic         Sel,
    output logic         AddSub,
    input  logic [n-1:0] Z,
    input  logic         Overflow,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [n-1:0] res_data,
    output logic         res_ovf,
    output logic         ovf_sticky,
    input  logic         clr_sticky
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_ADDAB = 2'b11
    } op_e;

    logic [n-1:0]  a_q, a_d, b_q, b_d;
    logic          sel_q, sel_d, sub_q, sub_d;
    logic [2:0]    stage_q, stage_d;
    logic          rdy_en_q;
    logic          sticky_q, sticky_d;
    logic          accept;
    logic [1:0]    inflight;
    logic [CW-1:0] occupancy;
    logic [CW:0]   committed;
    logic [n:0]    head_dat;

    assign accept = cmd_valid && cmd_ready;

    // Idle drives Z + 0 with Sel=1 so the adder's result register holds.
    always_comb begin
        a_d   = '0;
        b_d   = '0;
        sel_d = 1'b1;
        sub_d = 1'b0;
        if (accept) begin
            case (op_e'(cmd_op))
                OP_LOAD:  begin sel_d = 1'b0; a_d = cmd_a; end
                OP_ADD:   begin b_d = cmd_b; end
                OP_SUB:   begin sub_d = 1'b1; b_d = cmd_b; end
                OP_ADDAB: begin sel_d = 1'b0; a_d = cmd_a; b_d = cmd_b; end
            endcase
        end
    end

    always_comb begin
        stage_d  = {stage_q[1:0], accept};
        sticky_d = sticky_q;
        // A set on the same edge as a clear wins.
        if (stage_q[2] && Overflow) sticky_d = 1'b1;
        else if (clr_sticky)        sticky_d = 1'b0;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b1;
            sub_q    <= 1'b0;
            stage_q  <= '0;
            rdy_en_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            sub_q    <= sub_d;
            stage_q  <= stage_d;
            rdy_en_q <= 1'b1;
            sticky_q <= sticky_d;
        end
    end

    addsub_fifo #(.W(n + 1), .DEPTH(DEPTH)) u_res_fifo (
        .clk_i      (Clock),
        .rst_n_i    (Resetn),
        .push_i     (stage_q[2]),
        .push_dat_i ({Overflow, Z}),
        .pop_i      (res_ready),
        .head_vld_o (res_valid),
        .head_dat_o (head_dat),
        .count_o    (occupancy)
    );

    // Every in-flight op owns a buffer slot, so capture never meets a full buffer.
    assign inflight  = {1'b0, stage_q[0]} + {1'b0, stage_q[1]} + {1'b0, stage_q[2]};
    assign committed = {1'b0, occupancy} + (CW + 1)'(inflight);
    assign cmd_ready = rdy_en_q && (committed < (CW + 1)'(DEPTH));

    assign A          = a_q;
    assign B          = b_q;
    assign Sel        = sel_q;
    assign AddSub     = sub_q;
    assign res_data   = head_dat[n-1:0];
    assign res_ovf    = head_dat[n];
    assign ovf_sticky = sticky_q;
endmodule
